multicycle_control_unit: RTL and testbench

- Multi-cycle MIPS controller FSM that replaces the single-cycle decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, sharing one ALU and one memory port.
- Adds a memory ready-handshake with wait states.
- Sits between the instruction register (operation/func fields) and the multi-cycle datapath muxes and enables.

---
 rtl/multicycle_control_unit.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/writeback over a shared ALU and memory port.
// Optional performance counters are built only when MCU_PERF_CNT_EN is defined.
module multicycle_control_unit #(
   parameter bit          MEM_HANDSHAKE = 1'b1,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       operation,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_re,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             reg_we,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             imm_zext,
   output logic [2:0]       alu_control,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_IMM_EXEC  = 4'd9,
      S_IMM_WB    = 4'd10,
      S_JUMP      = 4'd11,
      S_JR        = 4'd12,
      S_ILLEGAL   = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_SRA = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state_q;
   state_t     next_state;
   logic       ready;
   logic       func_legal;
   logic       func_shamt;
   logic [2:0] func_alu;

   // With the handshake disabled every memory access completes in one cycle.
   assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign state = state_q;

   // R-type funct decode: legality, ALU operation and shamt-operand select
   always_comb begin
      func_legal = 1'b1;
      func_shamt = 1'b0;
      func_alu   = ALU_AND;
      case (func)
         FN_AND:  func_alu = ALU_AND;
         FN_OR:   func_alu = ALU_OR;
         FN_ADD:  func_alu = ALU_ADD;
         FN_SUB:  func_alu = ALU_SUB;
         FN_SLT:  func_alu = ALU_SLT;
         FN_SLLV: func_alu = ALU_SLL;
         FN_SRLV: func_alu = ALU_SRL;
         FN_SRAV: func_alu = ALU_SRA;
         FN_SLL: begin
            func_alu   = ALU_SLL;
            func_shamt = 1'b1;
         end
         FN_SRL: begin
            func_alu   = ALU_SRL;
            func_shamt = 1'b1;
         end
         FN_SRA: begin
            func_alu   = ALU_SRA;
            func_shamt = 1'b1;
         end
         FN_JR:   func_alu = ALU_AND;
         default: func_legal = 1'b0;
      endcase
   end

   // Next-state logic
   always_comb begin
      next_state = state_q;
      case (state_q)
         S_FETCH:    next_state = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (operation)
               OP_RTYPE: begin
                  if (!func_legal)        next_state = S_ILLEGAL;
                  else if (func == FN_JR) next_state = S_JR;
                  else                    next_state = S_EXECUTE;
               end
               OP_LW, OP_SW:            next_state = S_MEM_ADR;
               OP_BEQ, OP_BNE:          next_state = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI: next_state = S_IMM_EXEC;
               OP_J:                    next_state = S_JUMP;
               default:                 next_state = S_ILLEGAL;
            endcase
         end
         S_MEM_ADR:   next_state = (operation == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  next_state = ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    next_state = S_FETCH;
         S_MEM_WRITE: next_state = ready ? S_FETCH : S_MEM_WRITE;
         S_EXECUTE:   next_state = S_ALU_WB;
         S_ALU_WB:    next_state = S_FETCH;
         S_BRANCH:    next_state = S_FETCH;
         S_IMM_EXEC:  next_state = S_IMM_WB;
         S_IMM_WB:    next_state = S_FETCH;
         S_JUMP:      next_state = S_FETCH;
         S_JR:        next_state = S_FETCH;
         S_ILLEGAL:   next_state = S_FETCH;
         default:     next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= next_state;
   end

   // Datapath controls decoded from state; branch and memory-ready enables also see inputs.
   always_comb begin
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 2'b00;
      reg_we      = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_zext    = 1'b0;
      alu_control = ALU_AND;
      illegal     = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_re      = 1'b1;
            alu_src_b   = 2'b01;
            alu_control = ALU_ADD;
            ir_we       = ready;
            pc_we       = ready;
         end
         S_DECODE: begin
            alu_src_b   = 2'b11;
            alu_control = ALU_ADD;
         end
         S_MEM_ADR: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            alu_control = ALU_ADD;
         end
         S_MEM_READ: begin
            mem_re = 1'b1;
            iord   = 1'b1;
         end
         S_MEM_WB: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_we = 1'b1;
            iord   = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a   = func_shamt ? 2'b10 : 2'b01;
            alu_control = func_alu;
         end
         S_ALU_WB: begin
            reg_we  = 1'b1;
            reg_dst = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b01;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            pc_we       = (operation == OP_BEQ && zero) || (operation == OP_BNE && !zero);
         end
         S_IMM_EXEC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            case (operation)
               OP_ANDI: begin
                  alu_control = ALU_AND;
                  imm_zext    = 1'b1;
               end
               OP_ORI: begin
                  alu_control = ALU_OR;
                  imm_zext    = 1'b1;
               end
               default: alu_control = ALU_ADD;
            endcase
         end
         S_IMM_WB: reg_we = 1'b1;
         S_JUMP: begin
            pc_we  = 1'b1;
            pc_src = 2'b10;
         end
         S_JR: begin
            pc_we  = 1'b1;
            pc_src = 2'b11;
         end
         S_ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
      // A reset cycle must never write or request anything.
      if (reset) begin
         mem_re  = 1'b0;
         mem_we  = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         reg_we  = 1'b0;
         illegal = 1'b0;
      end
   end

`ifdef MCU_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] instr_q;

   // Retired instructions are counted on the return to FETCH; skipped illegal ones are not.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_q + CNT_W'(1);
         if (next_state == S_FETCH && state_q != S_FETCH && state_q != S_ILLEGAL)
            instr_q <= instr_q + CNT_W'(1);
      end
   end

   assign cycle_count = cycle_q;
   assign instr_count = instr_q;
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit: per-cycle table plus latency and counter sequences.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  operation;
   logic [5:0]  func;
   logic        zero;
   logic        mem_ready;
   logic        mem_re, mem_we, iord, ir_we, pc_we;
   logic [1:0]  pc_src;
   logic        reg_we, reg_dst, mem_to_reg;
   logic [1:0]  alu_src_a, alu_src_b;
   logic        imm_zext;
   logic [2:0]  alu_control;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] cycle_count, instr_count;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .reset(reset), .operation(operation), .func(func), .zero(zero),
      .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
      .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_zext(imm_zext), .alu_control(alu_control), .illegal(illegal), .state(state),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   typedef struct packed {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        rdy;
      logic [3:0]  st;
      logic [18:0] outs;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   // enable field order: mem_re mem_we iord ir_we pc_we reg_we reg_dst mem_to_reg imm_zext illegal
   logic [18:0] act;
   assign act = {mem_re, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg, imm_zext, illegal,
                 pc_src, alu_src_a, alu_src_b, alu_control};

   task automatic add_vec(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic rdy, input logic [3:0] st,
                          input logic [9:0] en, input logic [1:0] ps, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [2:0] al);
      vec_t v;
      v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st;
      v.outs = {en, ps, sa, sb, al};
      vq.push_back(v);
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Cycles from a FETCH with ready until the next return to FETCH; -1 on timeout.
   task automatic measure(output int n);
      n = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (state == 4'd0) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1; operation = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;

      // reset held three cycles
      for (int i = 0; i < 3; i++)
         add_vec(1, 6'b000000, 6'b100000, 0, 1, 4'd0,  10'b0000000000, 2'b00, 2'b00, 2'b01, 3'b010);
      // add, with one FETCH wait first
      add_vec(0, 6'b000000, 6'b100000, 0, 0, 4'd0,  10'b1000000000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000000, 6'b100000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000000, 6'b100000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b000000, 6'b100000, 0, 1, 4'd6,  10'b0000000000, 2'b00, 2'b01, 2'b00, 3'b010);
      add_vec(0, 6'b000000, 6'b100000, 0, 1, 4'd7,  10'b0000011000, 2'b00, 2'b00, 2'b00, 3'b000);
      // lw with two wait cycles in MEM_READ
      add_vec(0, 6'b100011, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b100011, 6'b000000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b100011, 6'b000000, 0, 1, 4'd2,  10'b0000000000, 2'b00, 2'b01, 2'b10, 3'b010);
      add_vec(0, 6'b100011, 6'b000000, 0, 0, 4'd3,  10'b1010000000, 2'b00, 2'b00, 2'b00, 3'b000);
      add_vec(0, 6'b100011, 6'b000000, 0, 0, 4'd3,  10'b1010000000, 2'b00, 2'b00, 2'b00, 3'b000);
      add_vec(0, 6'b100011, 6'b000000, 0, 1, 4'd3,  10'b1010000000, 2'b00, 2'b00, 2'b00, 3'b000);
      add_vec(0, 6'b100011, 6'b000000, 0, 1, 4'd4,  10'b0000010100, 2'b00, 2'b00, 2'b00, 3'b000);
      // beq taken, then bne not taken, both with zero=1
      add_vec(0, 6'b000100, 6'b000000, 1, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000100, 6'b000000, 1, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b000100, 6'b000000, 1, 1, 4'd8,  10'b0000100000, 2'b01, 2'b01, 2'b00, 3'b110);
      add_vec(0, 6'b000101, 6'b000000, 1, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000101, 6'b000000, 1, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b000101, 6'b000000, 1, 1, 4'd8,  10'b0000000000, 2'b01, 2'b01, 2'b00, 3'b110);
      // sll uses the shamt operand
      add_vec(0, 6'b000000, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000000, 6'b000000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b000000, 6'b000000, 0, 1, 4'd6,  10'b0000000000, 2'b00, 2'b10, 2'b00, 3'b011);
      add_vec(0, 6'b000000, 6'b000000, 0, 1, 4'd7,  10'b0000011000, 2'b00, 2'b00, 2'b00, 3'b000);
      // andi zero-extends
      add_vec(0, 6'b001100, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b001100, 6'b000000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b001100, 6'b000000, 0, 1, 4'd9,  10'b0000000010, 2'b00, 2'b01, 2'b10, 3'b000);
      add_vec(0, 6'b001100, 6'b000000, 0, 1, 4'd10, 10'b0000010000, 2'b00, 2'b00, 2'b00, 3'b000);
      // unsupported opcode
      add_vec(0, 6'b111111, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b111111, 6'b000000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b111111, 6'b000000, 0, 1, 4'd13, 10'b0000000001, 2'b00, 2'b00, 2'b00, 3'b000);
      // j and jr
      add_vec(0, 6'b000010, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000010, 6'b000000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b000010, 6'b000000, 0, 1, 4'd11, 10'b0000100000, 2'b10, 2'b00, 2'b00, 3'b000);
      add_vec(0, 6'b000000, 6'b001000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000000, 6'b001000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b000000, 6'b001000, 0, 1, 4'd12, 10'b0000100000, 2'b11, 2'b00, 2'b00, 3'b000);
      // R-type with unsupported funct
      add_vec(0, 6'b000000, 6'b000001, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000000, 6'b000001, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b000000, 6'b000001, 0, 1, 4'd13, 10'b0000000001, 2'b00, 2'b00, 2'b00, 3'b000);
      // sw held in MEM_WRITE, then reset mid-instruction
      add_vec(0, 6'b101011, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b101011, 6'b000000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b101011, 6'b000000, 0, 1, 4'd2,  10'b0000000000, 2'b00, 2'b01, 2'b10, 3'b010);
      add_vec(0, 6'b101011, 6'b000000, 0, 0, 4'd5,  10'b0110000000, 2'b00, 2'b00, 2'b00, 3'b000);
      add_vec(1, 6'b101011, 6'b000000, 0, 0, 4'd5,  10'b0010000000, 2'b00, 2'b00, 2'b00, 3'b000);
      add_vec(0, 6'b101011, 6'b000000, 0, 0, 4'd0,  10'b1000000000, 2'b00, 2'b00, 2'b01, 3'b010);
      // bne taken with zero=0
      add_vec(0, 6'b000101, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b000101, 6'b000000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b000101, 6'b000000, 0, 1, 4'd8,  10'b0000100000, 2'b01, 2'b01, 2'b00, 3'b110);
      // ori
      add_vec(0, 6'b001101, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);
      add_vec(0, 6'b001101, 6'b000000, 0, 1, 4'd1,  10'b0000000000, 2'b00, 2'b00, 2'b11, 3'b010);
      add_vec(0, 6'b001101, 6'b000000, 0, 1, 4'd9,  10'b0000000010, 2'b00, 2'b01, 2'b10, 3'b001);
      add_vec(0, 6'b001101, 6'b000000, 0, 1, 4'd10, 10'b0000010000, 2'b00, 2'b00, 2'b00, 3'b000);
      add_vec(0, 6'b001101, 6'b000000, 0, 1, 4'd0,  10'b1001100000, 2'b00, 2'b00, 2'b01, 3'b010);

      @(posedge clk); #1;
      for (int i = 0; i < vq.size(); i++) begin
         reset = vq[i].rst; operation = vq[i].op; func = vq[i].fn;
         zero = vq[i].z; mem_ready = vq[i].rdy;
         @(negedge clk);
         n_vec++;
         if (state !== vq[i].st || act !== vq[i].outs) begin
            n_err++;
            $display("FAIL vec%0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                     i, state, act, vq[i].st, vq[i].outs);
         end
         @(posedge clk); #1;
      end

      // latency sequences with zero wait states, and the counters across them
      do_reset();
      zero = 1'b0; func = 6'b000000;
      operation = 6'b000010; measure(n); check("j_latency", n, 3);
      operation = 6'b111111; measure(n); check("illegal_latency", n, 3);
`ifdef MCU_PERF_CNT_EN
      check("cycle_count", int'(cycle_count), 6);
      check("instr_count", int'(instr_count), 1);
`else
      check("cycle_count_tied", int'(cycle_count), 0);
      check("instr_count_tied", int'(instr_count), 0);
`endif
      operation = 6'b100011; measure(n); check("lw_latency", n, 5);
      operation = 6'b101011; measure(n); check("sw_latency", n, 4);
      operation = 6'b001000; measure(n); check("addi_latency", n, 4);
      operation = 6'b000100; measure(n); check("beq_latency", n, 3);
      operation = 6'b000000; func = 6'b101010; measure(n); check("slt_latency", n, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
